// File: rtl/writeback_unit_pkg.sv
// Shared CPU definitions used by the write-back stage and the memory stage.
// Holds instruction field positions, the bubble encoding, register-file
// port-2 select encodings, the write-back FSM state type and the
// memory-class decode helpers.
package writeback_unit_pkg;

  // Instruction field positions
  localparam int COND_HI   = 31;
  localparam int COND_LO   = 28;
  localparam int OPCODE_HI = 27;
  localparam int OPCODE_LO = 21;
  localparam int RN_HI     = 19;
  localparam int RN_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 12;

  // Bubble instruction: cond field 1111 marks "never execute"
  localparam logic [31:0] NOP_INSTR  = 32'hF000_0000;
  localparam logic [3:0]  COND_NEVER = 4'hF;

  // Register-file port 2 select encodings (10 and 11 are unused)
  typedef enum logic [1:0] {
    W_ADDR_RD = 2'b00,
    W_ADDR_RN = 2'b01
  } w_addr_sel_t;

  typedef enum logic [1:0] {
    W_DATA_MEM = 2'b00,
    W_DATA_ALU = 2'b01
  } w_data_sel_t;

  // Write-back FSM states; WB_BASE is the second write of a post-indexed LDR
  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_BASE = 1'b1
  } wb_state_t;

  // Memory class: opcode 11xxxxx or 1000xxx
  function automatic logic is_mem(input logic [6:0] opcode);
    return (opcode[6:5] == 2'b11) || (opcode[6:3] == 4'b1000);
  endfunction

  function automatic logic is_str(input logic [6:0] opcode);
    return opcode[4];
  endfunction

  // P: pre-indexed (1) / post-indexed (0)
  function automatic logic p_bit(input logic [6:0] opcode);
    return opcode[2];
  endfunction

  // U: add (1) / subtract (0) offset
  function automatic logic u_bit(input logic [6:0] opcode);
    return opcode[1];
  endfunction

  // W: write-back of the computed address
  function automatic logic w_bit(input logic [6:0] opcode);
    return opcode[0];
  endfunction

endpackage

// File: rtl/writeback_pipeline_unit.sv
// Stall-holdable pipeline register between the memory stage and write-back.
// Captures the instruction and its branch-path tag on every clock unless
// hold is high, and exposes the decoded fields of the held instruction.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   hold               keep the current contents this cycle
//   instr_in/branch_in instruction and tag from the memory stage
//   instr_q/tag_q      held instruction and tag
//   cond/opcode/rn/rd  decoded fields of instr_q
module writeback_pipeline_unit
  import writeback_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic [31:0] instr_in,
  input  logic        branch_in,
  output logic [31:0] instr_q,
  output logic        tag_q,
  output logic [3:0]  cond,
  output logic [6:0]  opcode,
  output logic [3:0]  rn,
  output logic [3:0]  rd
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      tag_q   <= 1'b0;
    end else if (!hold) begin
      instr_q <= instr_in;
      tag_q   <= branch_in;
    end
  end

  assign cond   = instr_q[COND_HI:COND_LO];
  assign opcode = instr_q[OPCODE_HI:OPCODE_LO];
  assign rn     = instr_q[RN_HI:RN_LO];
  assign rd     = instr_q[RD_HI:RD_LO];

endmodule

// File: rtl/writeback_unit.sv
// Write-back controller: final stage of the pipelined CPU.
// Squashes instructions from a stale branch path and drives register-file
// write port 2 for load results and post-indexed base updates. A
// post-indexed LDR needs two writes (rd, then rn), so the FSM spends one
// extra cycle in WB_BASE and stalls upstream for the first of the two.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   instr_in, branch_in instruction and branch tag from the memory stage
//   branch_ref_global   current branch reference
//   w_en2               port-2 write enable
//   sel_w_addr2         00 = rd, 01 = rn
//   sel_w_data2         00 = memory read data, 01 = registered ALU result
//   stall_out           hold upstream pipeline registers and PC
//   rd, rn              fields of the held instruction, for forwarding
//   instr_output        held instruction, or the bubble when squashed
//   wb_busy             high while in WB_BASE (exposes the FSM state)
module writeback_unit
  import writeback_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_in,
  input  logic        branch_in,
  input  logic        branch_ref_global,
  output logic        w_en2,
  output logic [1:0]  sel_w_addr2,
  output logic [1:0]  sel_w_data2,
  output logic        stall_out,
  output logic [3:0]  rd,
  output logic [3:0]  rn,
  output logic [31:0] instr_output,
  output logic        wb_busy
);

  wb_state_t   state, state_nxt;
  logic        stall;
  logic [31:0] instr_q;
  logic        tag_q;
  logic [3:0]  cond;
  logic [6:0]  opcode;
  logic        valid;

  writeback_pipeline_unit u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (stall),
    .instr_in  (instr_in),
    .branch_in (branch_in),
    .instr_q   (instr_q),
    .tag_q     (tag_q),
    .cond      (cond),
    .opcode    (opcode),
    .rn        (rn),
    .rd        (rd)
  );

  assign valid = (cond != COND_NEVER) && (tag_q == branch_ref_global);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    w_en2       = 1'b0;
    sel_w_addr2 = W_ADDR_RD;
    sel_w_data2 = W_DATA_MEM;
    stall       = 1'b0;
    wb_busy     = 1'b0;
    case (state)
      WB_IDLE: begin
        if (valid && is_mem(opcode)) begin
          if (!is_str(opcode)) begin
            // LDR: load result to rd; post-indexed also needs the base write
            w_en2 = 1'b1;
            if (!p_bit(opcode)) begin
              stall     = 1'b1;
              state_nxt = WB_BASE;
            end
          end else if (!p_bit(opcode)) begin
            // Post-indexed STR: base update only
            w_en2       = 1'b1;
            sel_w_addr2 = W_ADDR_RN;
            sel_w_data2 = W_DATA_ALU;
          end
        end
      end
      WB_BASE: begin
        // Instruction already committed by the first write: ignore the tag
        w_en2       = 1'b1;
        sel_w_addr2 = W_ADDR_RN;
        sel_w_data2 = W_DATA_ALU;
        wb_busy     = 1'b1;
        state_nxt   = WB_IDLE;
      end
    endcase
  end

  assign stall_out    = stall;
  assign instr_output = valid ? instr_q : NOP_INSTR;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed reset checks, a scripted plus random
// instruction stream checked per output cycle, and reset during WB_BASE.
module tb_writeback_unit;

  localparam int          EW  = 47;
  localparam int          NT  = 90;
  localparam logic [31:0] NOP = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_in;
  logic        branch_in;
  logic        branch_ref_global;
  logic        w_en2;
  logic [1:0]  sel_w_addr2;
  logic [1:0]  sel_w_data2;
  logic        stall_out;
  logic [3:0]  rd;
  logic [3:0]  rn;
  logic [31:0] instr_output;
  logic        wb_busy;

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  logic [31:0] t_instr[NT];
  logic        t_tag[NT];
  logic        t_rf[NT];
  logic        t_rb[NT];

  writeback_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .instr_in          (instr_in),
    .branch_in         (branch_in),
    .branch_ref_global (branch_ref_global),
    .w_en2             (w_en2),
    .sel_w_addr2       (sel_w_addr2),
    .sel_w_data2       (sel_w_data2),
    .stall_out         (stall_out),
    .rd                (rd),
    .rn                (rn),
    .instr_output      (instr_output),
    .wb_busy           (wb_busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(int cond, int opc, int rn_f, int rd_f);
    logic [11:0] low;
    low = 12'h0A5;
    return {cond[3:0], opc[6:0], 1'b0, rn_f[3:0], rd_f[3:0], low};
  endfunction

  // Expected output vector: {w_en2, addr sel, data sel, stall, busy, instr_output, rd, rn}
  function automatic logic [EW-1:0] ent(bit w, int a, int d, bit st, bit bs,
                                        logic [31:0] io, logic [31:0] ins);
    return {w, a[1:0], d[1:0], st, bs, io, ins[15:12], ins[19:16]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference model: expected output cycles of transaction i
  task automatic push_expected(input int i, output int cycles);
    logic [31:0] ins;
    int cond, opc;
    bit mem, str, p, valid;
    ins   = t_instr[i];
    cond  = int'(ins[31:28]);
    opc   = int'(ins[27:21]);
    mem   = (opc >= 96) || (opc >= 64 && opc <= 71);
    str   = ((opc / 16) % 2) == 1;
    p     = ((opc / 4) % 2) == 1;
    valid = (cond != 15) && (t_tag[i] == t_rf[i]);
    cycles = 1;
    if (!valid)
      exp_q.push_back(ent(0, 0, 0, 0, 0, NOP, ins));
    else if (mem && !str && p)
      exp_q.push_back(ent(1, 0, 0, 0, 0, ins, ins));
    else if (mem && !str && !p) begin
      exp_q.push_back(ent(1, 0, 0, 1, 0, ins, ins));
      exp_q.push_back(ent(1, 1, 1, 0, 1, (t_tag[i] == t_rb[i]) ? ins : NOP, ins));
      cycles = 2;
    end else if (mem && str && !p)
      exp_q.push_back(ent(1, 1, 1, 0, 0, ins, ins));
    else
      exp_q.push_back(ent(0, 0, 0, 0, 0, ins, ins));
  endtask

  // Scoreboard monitor: one expected entry per output cycle
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        logic [EW-1:0] e, a;
        e = exp_q.pop_front();
        a = {w_en2, sel_w_addr2, sel_w_data2, stall_out, wb_busy, instr_output, rd, rn};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL sb_cycle t=%0t act=%h exp=%h", $time, a, e);
        end
      end
    end
  end

  task automatic set_txn(input int i, input logic [31:0] ins, input logic tag,
                         input logic rf, input logic rb);
    t_instr[i] = ins;
    t_tag[i]   = tag;
    t_rf[i]    = rf;
    t_rb[i]    = rb;
  endtask

  initial begin
    int prev;
    int guard;
    rst_n = 1'b0;
    instr_in = NOP;
    branch_in = 1'b0;
    branch_ref_global = 1'b0;

    // Scripted transactions (instr, tag, ref in first cycle, ref in base cycle)
    set_txn(0,  mk(14, 100, 1, 3), 0, 0, 0);  // LDR pre, rd=3
    set_txn(1,  mk(14, 98, 5, 2),  0, 0, 0);  // LDR post, rd=2 rn=5
    set_txn(2,  mk(14, 112, 4, 7), 0, 0, 0);  // STR post
    set_txn(3,  mk(14, 116, 4, 7), 0, 0, 0);  // STR pre: no write
    set_txn(4,  mk(14, 100, 6, 8), 0, 1, 1);  // stale tag
    set_txn(5,  mk(14, 98, 9, 1),  1, 1, 0);  // LDR post, ref toggles in base
    set_txn(6,  mk(14, 98, 10, 11), 1, 1, 1); // back-to-back LDR post
    set_txn(7,  mk(14, 99, 12, 13), 1, 1, 1);
    set_txn(8,  mk(14, 98, 3, 4),  0, 1, 1);  // stale LDR post: no stall
    set_txn(9,  mk(15, 98, 3, 4),  1, 1, 1);  // bubble
    set_txn(10, mk(14, 4, 2, 6),   1, 1, 1);  // non-memory
    set_txn(11, mk(0, 66, 7, 9),   1, 1, 1);  // LDR post via 1000xxx
    for (int i = 12; i < NT - 1; i++) begin
      logic rf;
      int cond, opc, sel;
      rf = ($urandom_range(0, 4) == 0) ? ~t_rf[i-1] : t_rf[i-1];
      cond = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 14));
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      opc = int'($urandom_range(0, 127));
      else if (sel == 1) opc = 64 + int'($urandom_range(0, 7));
      else               opc = 96 + int'($urandom_range(0, 31));
      set_txn(i, mk(cond, opc, int'($urandom_range(0, 15)), int'($urandom_range(0, 15))),
              ($urandom_range(0, 4) == 0) ? ~rf : rf, rf,
              ($urandom_range(0, 3) == 0) ? ~rf : rf);
    end
    set_txn(NT - 1, NOP, 0, 0, 0);

    // Reset state
    #12;
    chk("rst_instr_output", instr_output, NOP);
    chk("rst_w_en2", {31'b0, w_en2}, 32'd0);
    chk("rst_stall", {31'b0, stall_out}, 32'd0);
    chk("rst_busy", {31'b0, wb_busy}, 32'd0);
    chk("rst_sels", {28'b0, sel_w_addr2, sel_w_data2}, 32'd0);
    chk("rst_rd_rn", {24'b0, rd, rn}, 32'd0);

    // Asynchronous reset mid-cycle while a load is writing
    @(negedge clk);
    rst_n = 1'b1;
    instr_in = mk(14, 100, 1, 3);
    branch_in = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst_w_en2", {31'b0, w_en2}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_instr", instr_output, NOP);
    chk("async_rst_w_en2", {31'b0, w_en2}, 32'd0);
    chk("async_rst_stall", {31'b0, stall_out}, 32'd0);
    instr_in = NOP;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("bubble_no_write", {31'b0, w_en2}, 32'd0);
    chk("bubble_instr", instr_output, NOP);

    // Transaction stream; upstream holds its instruction while stalled
    prev = 1;
    for (int i = 0; i < NT; i++) begin
      for (int c = 0; c < prev; c++) begin
        @(negedge clk);
        instr_in  = t_instr[i];
        branch_in = t_tag[i];
        if (i > 0) branch_ref_global = (c == 0) ? t_rf[i-1] : t_rb[i-1];
        @(posedge clk);
      end
      push_expected(i, prev);
    end
    @(negedge clk);
    branch_ref_global = t_rf[NT-1];
    instr_in = NOP;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    total++;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain act=%0d exp=0", exp_q.size());
      exp_q.delete();
    end

    // Reset during WB_BASE abandons the base write
    @(negedge clk);
    instr_in  = mk(14, 98, 5, 2);
    branch_in = branch_ref_global;
    @(posedge clk);
    #2;
    chk("rb_stall", {31'b0, stall_out}, 32'd1);
    @(negedge clk);
    instr_in = NOP;
    @(posedge clk);
    #2;
    chk("rb_busy", {31'b0, wb_busy}, 32'd1);
    chk("rb_base_sel", {28'b0, sel_w_addr2, sel_w_data2}, 32'h5);
    #1 rst_n = 1'b0;
    #1;
    chk("rb_rst_busy", {31'b0, wb_busy}, 32'd0);
    chk("rb_rst_w_en2", {31'b0, w_en2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("rb_after_busy", {31'b0, wb_busy}, 32'd0);
    chk("rb_after_w_en2", {31'b0, w_en2}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Final controller stage of the pipelined CPU, directly downstream of the memory-stage controller. Registers the instruction leaving the memory stage together with its branch tag, discards instructions from a stale branch path, and drives register-file write port 2 for load results and post-indexed base updates. An LDR with post-indexing needs two writes, so the block runs a two-state FSM and stalls the upstream stages for one cycle.

## Interface
- Parameters: none.
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- instr_in  in  32  instruction leaving the memory stage
- branch_in  in  1  branch-path tag carried with instr_in
- branch_ref_global  in  1  current branch reference from the memory stage
- w_en2  out  1  write enable, register-file port 2
- sel_w_addr2  out  2  00 = rd, 01 = rn; 10 and 11 are never driven
- sel_w_data2  out  2  00 = memory read data, 01 = registered ALU result; 10 and 11 are never driven
- stall_out  out  1  hold upstream pipeline registers and PC this cycle
- rd  out  4  rd of the held instruction, used for forwarding
- rn  out  4  rn of the held instruction, used for forwarding
- instr_output  out  32  held instruction; the bubble value when squashed
- wb_busy  out  1  high while the FSM is in WB_BASE

## Operation
**Field layout**
- cond = instr[31:28], opcode = instr[27:21], rn = instr[19:16], rd = instr[15:12].

**Instruction classes**
- Memory class: opcode[6:5]==11 or opcode[6:3]==1000.
- Within the memory class: opcode[4]=1 is STR, otherwise LDR. P=opcode[2], U=opcode[1], W=opcode[0].
- Bubble: cond==1111. The bubble constant is 32'hF000_0000.

**Validity**
- The held instruction is valid iff cond!=1111 and held tag == branch_ref_global.
- An invalid instruction produces no writes, no stall, and instr_output = bubble.

**FSM states**
- WB_IDLE (reset state).
- WB_BASE.

**WB_IDLE, valid instruction**
- LDR with P=1: w_en2=1, sel_w_addr2=00, sel_w_data2=00. Remain in WB_IDLE.
- STR with P=0: w_en2=1, sel_w_addr2=01, sel_w_data2=01. Remain in WB_IDLE.
- LDR with P=0: w_en2=1, addr=rd, data=mem. stall_out=1. Next state WB_BASE.
- STR with P=1, and all non-memory classes: no write.

**WB_BASE**
- Outputs: w_en2=1, sel_w_addr2=01, sel_w_data2=01, stall_out=0, wb_busy=1.
- Next state: WB_IDLE, unconditionally.
- The first write already committed the instruction, so the second write completes even if branch_ref_global toggles during WB_BASE.

**Pipeline register**
- Loads instr_in and branch_in on every clock, except when stall_out=1; then it holds its value.
- The held value is therefore still present in WB_BASE.
- After WB_BASE, the register takes the instruction the upstream stage held during the stall.

**Default outputs**
- Whenever no rule above applies: w_en2=0, sel_w_addr2=00, sel_w_data2=00, stall_out=0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - Pipeline register = 32'hF000_0000, tag = 0, state = WB_IDLE.
  - All outputs read 0, except instr_output = 32'hF000_0000 and rd = rn = 0.
- Latency: an instruction presented on instr_in at edge N drives outputs combinationally during cycle N+1. The register file writes at edge N+2.
- stall_out is a combinational function of the held instruction and the state. It is asserted for exactly one cycle per post-indexed LDR and is never asserted twice in a row.
- Back-to-back post-indexed LDRs take 4 cycles in total: IDLE(stall), BASE, IDLE(stall), BASE.
- Reset asserted during WB_BASE: the FSM returns to WB_IDLE and the base write is abandoned. The architectural result is discarded by the system-level reset.
- Tag mismatch arriving on the same edge as a post-indexed LDR: the instruction is squashed, with no writes and no stall.

## Structure
Put the following in the shared CPU package, not in this block:
- Field-position constants (COND_HI/LO, OPCODE_HI/LO, RN_HI/LO, RD_HI/LO).
- The bubble constant NOP_INSTR = 32'hF000_0000.
- The write-address and write-data select encodings.
- The FSM enum wb_state_t {WB_IDLE, WB_BASE}.
- Memory-class decode helper functions (is_mem, is_str, p_bit, u_bit, w_bit), shared with the memory stage.

Sub-module: one, writeback_pipeline_unit. It is the stall-holdable register for instr and tag, and exposes the decoded fields. The FSM and output decode stay in writeback_unit.

## Test plan
- **Reset and bubble:** assert rst_n=0 mid-cycle → instr_output=F000_0000, w_en2=0, stall_out=0 immediately. Then send a bubble → no write.
- **LDR pre-indexed** (opcode 1100100, P=1, rd=3, tag=ref) → the following cycle has w_en2=1, addr sel 00, data sel 00, stall_out=0.
- **LDR post-indexed** (opcode 1100010, P=0, rd=2, rn=5):
  - Cycle 1: w_en2=1, sel 00/00, stall_out=1.
  - Cycle 2: w_en2=1, sel 01/01, wb_busy=1.
  - Cycle 3: the next instruction appears.
- **STR post-indexed** (opcode 1110000) → a single base write with sel 01/01 and no stall. STR with P=1 → no write.
- **Stale tag:** branch_in=0 while branch_ref_global=1 → instr_output=F000_0000, no writes. Toggling branch_ref_global during WB_BASE still completes the rn write.
- **Reset during WB_BASE** → state returns to WB_IDLE, w_en2=0, wb_busy=0.
